pool_rd: RTL and testbench

POOL_RD -- requirements
Module: pool_rd

---
 rtl/pool_rd_pkg.sv | 34 +++
 rtl/pool_max4_req.sv | 34 +++
 rtl/pool_rd.sv | 112 +++++++++++
 tb/tb_pool_rd.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_rd_pkg.sv
// Shared parameters, state encoding and sizing helpers for the pooling read engine.
package pool_rd_pkg;

    function automatic int unsigned cLog2(input int unsigned value);
        int unsigned r = 0;
        int unsigned v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned satMax(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    localparam int unsigned DATA_WIDTH_DEF    = 8;
    localparam int unsigned LENPSUM_DEF       = 16;
    localparam int unsigned CHANNEL_DEPTH_DEF = 32;
    localparam int unsigned PSUM_WIDTH_DEF    = DATA_WIDTH_DEF * 2 + cLog2(CHANNEL_DEPTH_DEF) + 2;
    localparam int unsigned PAIR_W_DEF        = cLog2(LENPSUM_DEF / 2);
    localparam int unsigned SAT_MAX_DEF       = satMax(DATA_WIDTH_DEF);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDA  = 3'd1,
        RDB  = 3'd2,
        CAPA = 3'd3,
        CMP  = 3'd4,
        OUT  = 3'd5
    } poolState_e;

endpackage

// File: rtl/pool_max4_req.sv
// One output element: signed 4-way max, ReLU, arithmetic right shift, unsigned saturation.
module pool_max4_req
    import pool_rd_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic signed [PSUM_WIDTH-1:0] a0,
    input  logic signed [PSUM_WIDTH-1:0] a1,
    input  logic signed [PSUM_WIDTH-1:0] b0,
    input  logic signed [PSUM_WIDTH-1:0] b1,
    input  logic        [4:0]            shift,
    output logic        [DATA_WIDTH-1:0] res_c
);

    localparam logic [DATA_WIDTH-1:0] SAT = DATA_WIDTH'(satMax(DATA_WIDTH));

    logic signed [PSUM_WIDTH-1:0] maxA;
    logic signed [PSUM_WIDTH-1:0] maxB;
    logic signed [PSUM_WIDTH-1:0] maxAll;
    logic signed [PSUM_WIDTH-1:0] relu;
    logic signed [PSUM_WIDTH-1:0] shifted;

    always_comb begin
        maxA    = (a0 > a1) ? a0 : a1;
        maxB    = (b0 > b1) ? b0 : b1;
        maxAll  = (maxA > maxB) ? maxA : maxB;
        relu    = maxAll[PSUM_WIDTH-1] ? '0 : maxAll;
        shifted = relu >>> shift;
        // relu is non-negative, so any set bit above the output width means overflow
        res_c   = (|shifted[PSUM_WIDTH-1:DATA_WIDTH]) ? SAT : shifted[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/pool_rd.sv
// Reads psum word pairs from SRAM, 2x2 max-pools them and hands out requantised rows.
module pool_rd
    import pool_rd_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int unsigned LENPSUM    = LENPSUM_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  CTRLPOOL_Start,
    input  logic [4:0]                            CTRLPOOL_Shift,
    output logic                                  POOLCTRL_Busy,
    output logic                                  POOLCTRL_Fnh,
    output logic                                  POOLPEB_EnRd,
    output logic [cLog2(LENPSUM)-1:0]             POOLPEB_AddrRd,
    input  logic [PSUM_WIDTH*LENPSUM-1:0]         PEBPOOL_Dat,
    output logic                                  POOLNXT_RdyDat,
    input  logic                                  NXTPOOL_GetDat,
    output logic [DATA_WIDTH*(LENPSUM/2)-1:0]     POOLNXT_Dat
);

    localparam int unsigned NOUT   = LENPSUM / 2;
    localparam int unsigned ADDR_W = cLog2(LENPSUM);
    localparam int unsigned PAIR_W = cLog2(NOUT);

    poolState_e                     state;
    logic [PAIR_W-1:0]              pairCnt;
    logic [4:0]                     shiftLat;
    logic [PSUM_WIDTH*LENPSUM-1:0]  rowA;
    logic [DATA_WIDTH*NOUT-1:0]     poolRow_c;

    // Row B is consumed straight from the SRAM bus in CMP, row A from its register
    for (genvar j = 0; j < NOUT; j++) begin : gMax
        pool_max4_req #(
            .PSUM_WIDTH(PSUM_WIDTH),
            .DATA_WIDTH(DATA_WIDTH)
        ) uMax (
            .a0    (rowA[(2*j)*PSUM_WIDTH +: PSUM_WIDTH]),
            .a1    (rowA[(2*j+1)*PSUM_WIDTH +: PSUM_WIDTH]),
            .b0    (PEBPOOL_Dat[(2*j)*PSUM_WIDTH +: PSUM_WIDTH]),
            .b1    (PEBPOOL_Dat[(2*j+1)*PSUM_WIDTH +: PSUM_WIDTH]),
            .shift (shiftLat),
            .res_c (poolRow_c[j*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            pairCnt        <= '0;
            shiftLat       <= '0;
            rowA           <= '0;
            POOLNXT_Dat    <= '0;
            POOLNXT_RdyDat <= 1'b0;
            POOLPEB_EnRd   <= 1'b0;
            POOLPEB_AddrRd <= '0;
            POOLCTRL_Busy  <= 1'b0;
            POOLCTRL_Fnh   <= 1'b0;
        end else begin
            POOLPEB_EnRd <= 1'b0;
            POOLCTRL_Fnh <= 1'b0;
            case (state)
                IDLE: begin
                    if (CTRLPOOL_Start) begin
                        shiftLat      <= CTRLPOOL_Shift;
                        pairCnt       <= '0;
                        POOLCTRL_Busy <= 1'b1;
                        state         <= RDA;
                    end
                end
                RDA: begin
                    POOLPEB_EnRd   <= 1'b1;
                    POOLPEB_AddrRd <= ADDR_W'({pairCnt, 1'b0});
                    state          <= RDB;
                end
                RDB: begin
                    POOLPEB_EnRd   <= 1'b1;
                    POOLPEB_AddrRd <= ADDR_W'({pairCnt, 1'b1});
                    state          <= CAPA;
                end
                CAPA: begin
                    rowA  <= PEBPOOL_Dat;
                    state <= CMP;
                end
                CMP: begin
                    POOLNXT_Dat    <= poolRow_c;
                    POOLNXT_RdyDat <= 1'b1;
                    state          <= OUT;
                end
                OUT: begin
                    if (NXTPOOL_GetDat) begin
                        POOLNXT_RdyDat <= 1'b0;
                        if (pairCnt == PAIR_W'(NOUT - 1)) begin
                            POOLCTRL_Fnh  <= 1'b1;
                            POOLCTRL_Busy <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            pairCnt <= pairCnt + PAIR_W'(1);
                            state   <= RDA;
                        end
                    end
                end
                default: begin
                    POOLCTRL_Busy <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_rd.sv
// Directed bench for pool_rd with a behavioural one-cycle-latency SRAM.
module tb_pool_rd;

    localparam int unsigned PW = 23;
    localparam int unsigned LP = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned NR = LP / 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [4:0]          shift;
    logic                busy;
    logic                fnh;
    logic                enRd;
    logic [3:0]          addrRd;
    logic [PW*LP-1:0]    rdDat = '0;
    logic                rdy;
    logic                get;
    logic [DW*NR-1:0]    dat;

    logic [PW*LP-1:0]    mem [LP];
    logic [DW*NR-1:0]    expRow [NR];

    int hits [LP] = '{default: 0};
    int enCnt = 0;
    int fnhCnt = 0;
    logic firstPending = 1'b0;
    logic [3:0] firstAddr = 4'hf;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pool_rd #(
        .PSUM_WIDTH(PW),
        .LENPSUM   (LP),
        .DATA_WIDTH(DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .CTRLPOOL_Start (start),
        .CTRLPOOL_Shift (shift),
        .POOLCTRL_Busy  (busy),
        .POOLCTRL_Fnh   (fnh),
        .POOLPEB_EnRd   (enRd),
        .POOLPEB_AddrRd (addrRd),
        .PEBPOOL_Dat    (rdDat),
        .POOLNXT_RdyDat (rdy),
        .NXTPOOL_GetDat (get),
        .POOLNXT_Dat    (dat)
    );

    // SRAM model plus read/finish monitors
    always @(posedge clk) begin
        if (enRd) begin
            rdDat         <= mem[addrRd];
            hits[addrRd]  <= hits[addrRd] + 1;
            enCnt         <= enCnt + 1;
            if (firstPending) begin
                firstAddr    <= addrRd;
                firstPending <= 1'b0;
            end
        end
        if (!rst_n) firstPending <= 1'b1;
        if (fnh) fnhCnt <= fnhCnt + 1;
    end

    task automatic fill_const(input int val);
        for (int r = 0; r < LP; r++)
            for (int i = 0; i < LP; i++)
                mem[r][i*PW +: PW] = PW'(val);
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < LP; r++)
            for (int i = 0; i < LP; i++)
                mem[r][i*PW +: PW] = PW'(r * 16 + i);
        for (int k = 0; k < NR; k++)
            for (int j = 0; j < NR; j++) begin
                int v;
                v = (2 * k + 1) * 16 + 2 * j + 1;
                expRow[k][j*DW +: DW] = DW'((v > 255) ? 255 : v);
            end
    endtask

    task automatic fill_exp_const(input int val);
        for (int k = 0; k < NR; k++)
            for (int j = 0; j < NR; j++)
                expRow[k][j*DW +: DW] = DW'(val);
    endtask

    // Runs one frame with Get high, optionally stalling at row stallRow for 10 cycles
    task automatic run_frame(input string tag, input logic [4:0] sh, input int stallRow);
        int rows = 0;
        int firstRdy = -1;
        int fnhAt = -1;
        int outEn = 0;
        int enBase;
        int fnhBase;
        int hitBase [LP];
        int expFnh;
        logic [DW*NR-1:0] held;
        enBase  = enCnt;
        fnhBase = fnhCnt;
        for (int i = 0; i < LP; i++) hitBase[i] = hits[i];
        get = 1'b1;
        @(negedge clk);
        start = 1'b1;
        shift = sh;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && fnhAt < 0; c++) begin
            if (enRd && rdy) outEn++;
            if (fnh) fnhAt = c;
            if (rdy && rows < NR) begin
                if (firstRdy < 0) firstRdy = c;
                vecs++;
                if (dat !== expRow[rows]) begin
                    errs++;
                    $display("FAIL %s row%0d: got %h expected %h", tag, rows, dat, expRow[rows]);
                end
                if (rows == stallRow) begin
                    get  = 1'b0;
                    held = dat;
                    for (int s = 0; s < 10; s++) begin
                        @(negedge clk);
                        c++;
                        vecs++;
                        if (rdy !== 1'b1 || dat !== held || enRd !== 1'b0) begin
                            errs++;
                            $display("FAIL %s stall%0d: rdy=%b enRd=%b dat=%h expected rdy=1 enRd=0 dat=%h",
                                     tag, s, rdy, enRd, dat, held);
                        end
                    end
                    vecs++;
                    if (enCnt - enBase !== 2 * (stallRow + 1)) begin
                        errs++;
                        $display("FAIL %s stall_reads: got %0d expected %0d", tag, enCnt - enBase, 2 * (stallRow + 1));
                    end
                    get = 1'b1;
                end
                rows++;
            end
            @(negedge clk);
        end
        expFnh = (stallRow >= 0) ? 50 : 40;
        vecs++;
        if (rows !== NR) begin errs++; $display("FAIL %s rows: got %0d expected %0d", tag, rows, NR); end
        vecs++;
        if (firstRdy !== 4) begin errs++; $display("FAIL %s latency: got %0d expected 4", tag, firstRdy); end
        vecs++;
        if (fnhAt !== expFnh) begin errs++; $display("FAIL %s fnh_cycle: got %0d expected %0d", tag, fnhAt, expFnh); end
        vecs++;
        if (fnhCnt - fnhBase !== 1) begin errs++; $display("FAIL %s fnh_count: got %0d expected 1", tag, fnhCnt - fnhBase); end
        vecs++;
        if (busy !== 1'b0) begin errs++; $display("FAIL %s busy_end: got %b expected 0", tag, busy); end
        vecs++;
        if (enCnt - enBase !== LP) begin errs++; $display("FAIL %s reads: got %0d expected %0d", tag, enCnt - enBase, LP); end
        vecs++;
        if (outEn !== 0) begin errs++; $display("FAIL %s enrd_in_out: got %0d expected 0", tag, outEn); end
        for (int i = 0; i < LP; i++) begin
            vecs++;
            if (hits[i] - hitBase[i] !== 1) begin
                errs++;
                $display("FAIL %s addr%0d: got %0d reads expected 1", tag, i, hits[i] - hitBase[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        shift = 5'd0;
        get   = 1'b0;
        fill_const(0);
        repeat (3) @(negedge clk);
        vecs++;
        if ({busy, fnh, enRd, rdy} !== 4'b0000 || addrRd !== 4'd0 || dat !== '0) begin
            errs++;
            $display("FAIL reset: busy=%b fnh=%b enRd=%b rdy=%b addr=%0d dat=%h expected all 0",
                     busy, fnh, enRd, rdy, addrRd, dat);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        fill_ramp();
        run_frame("ramp", 5'd0, -1);
    endtask

    task automatic test_negative();
        fill_const(-5);
        fill_exp_const(0);
        run_frame("negative", 5'd0, -1);
    endtask

    task automatic test_saturation();
        fill_const(4096);
        fill_exp_const(255);
        run_frame("sat_sh4", 5'd4, -1);
        fill_exp_const(128);
        run_frame("sat_sh5", 5'd5, -1);
    endtask

    task automatic test_backpressure();
        fill_ramp();
        run_frame("backpressure", 5'd0, 3);
    endtask

    task automatic test_busy_reset();
        int rows = 0;
        int fnhBase;
        fill_ramp();
        fnhBase = fnhCnt;
        get = 1'b1;
        @(negedge clk);
        start = 1'b1;
        shift = 5'd0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 60 && rows < 2; c++) begin
            if (c == 1) start = 1'b1;
            if (c == 2) begin start = 1'b0; shift = 5'd0; end
            if (c == 1) shift = 5'd5;
            if (rdy) begin
                vecs++;
                if (dat !== expRow[rows]) begin
                    errs++;
                    $display("FAIL busy_start row%0d: got %h expected %h", rows, dat, expRow[rows]);
                end
                rows++;
            end
            @(negedge clk);
        end
        for (int c = 0; c < 20 && !rdy; c++) @(negedge clk);
        rst_n = 1'b0;
        get   = 1'b0;
        repeat (2) @(negedge clk);
        vecs++;
        if ({busy, fnh, enRd, rdy} !== 4'b0000 || addrRd !== 4'd0 || dat !== '0) begin
            errs++;
            $display("FAIL midreset: busy=%b fnh=%b enRd=%b rdy=%b addr=%0d dat=%h expected all 0",
                     busy, fnh, enRd, rdy, addrRd, dat);
        end
        vecs++;
        if (fnhCnt - fnhBase !== 0) begin
            errs++;
            $display("FAIL abandon_fnh: got %0d pulses expected 0", fnhCnt - fnhBase);
        end
        rst_n = 1'b1;
        run_frame("after_reset", 5'd0, -1);
        vecs++;
        if (firstAddr !== 4'd0) begin
            errs++;
            $display("FAIL restart_addr: got %0d expected 0", firstAddr);
        end
    endtask

    task automatic test_addr_seq();
        fill_ramp();
        run_frame("addr_seq", 5'd0, -1);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_negative();
        test_saturation();
        test_backpressure();
        test_busy_reset();
        test_addr_seq();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
